// File: rtl/pipe_downsizer_pkg.sv
// Shared types for the pipeline downsizer.
//   pipeline_data_t   : 64-bit word carried by the pipeline / one_FIFO
//   DATA_W            : width of pipeline_data_t
//   downsizer_state_e : IDLE (nothing held) / SEND (word held, emitting beats)
package pipe_downsizer_pkg;

  typedef logic [63:0] pipeline_data_t;

  localparam int unsigned DATA_W = $bits(pipeline_data_t);

  typedef enum logic {
    DS_IDLE = 1'b0,
    DS_SEND = 1'b1
  } downsizer_state_e;

endpackage

// File: rtl/pipe_downsizer_if.sv
// Handshake bundle between one_FIFO, the downsizer and the narrow consumer.
//   valid_i/data_i/yumi_o : upstream word side (yumi_o dequeues the FIFO)
//   valid_o/ready_i/data_o/last_o : downstream beat side
//   busy_o                : downsizer currently holds a word
// Modports: slave = downsizer side, master = environment driving it.
interface pipe_downsizer_if
  import pipe_downsizer_pkg::*;
#(
  parameter int unsigned OUT_W = 32
);
  logic              valid_i;
  pipeline_data_t    data_i;
  logic              yumi_o;
  logic              valid_o;
  logic              ready_i;
  logic [OUT_W-1:0]  data_o;
  logic              last_o;
  logic              busy_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output yumi_o, valid_o, data_o, last_o, busy_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  yumi_o, valid_o, data_o, last_o, busy_o
  );
endinterface

// File: rtl/pipe_downsizer.sv
// Pops 64-bit words from one_FIFO (valid/yumi) and serialises each into
// DATA_W/OUT_W beats on a valid/ready output, flagging the final beat.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipe_downsizer_if.slave (interface OUT_W must equal OUT_W here)
// Parameters:
//   OUT_W     : beat width, must divide 64
//   LSB_FIRST : 1 = beat 0 is the least-significant slice, 0 = most-significant
module pipe_downsizer
  import pipe_downsizer_pkg::*;
#(
  parameter int unsigned OUT_W     = 32,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  pipe_downsizer_if.slave bus
);

  localparam int unsigned NBEATS = DATA_W / OUT_W;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned BASE_W = $clog2(DATA_W);

  if ((OUT_W == 0) || (DATA_W % OUT_W != 0)) begin : g_bad_width
    $error("pipe_downsizer: OUT_W must divide the pipeline word width exactly");
  end

  downsizer_state_e state_q;
  pipeline_data_t   hold_q;
  logic [CNT_W-1:0] cnt_q;

  logic              send;
  logic              last_beat;
  logic              beat_fire;
  logic              yumi;
  int unsigned       slice_idx;
  logic [BASE_W-1:0] slice_base;

  assign send      = (state_q == DS_SEND);
  assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));
  assign beat_fire = send & bus.ready_i;

  // Pop when empty, or in the same cycle the last beat leaves so a waiting
  // word follows with no bubble. Never depends on data_i.
  assign yumi = bus.valid_i & ~rst & (~send | (beat_fire & last_beat));

  always_comb begin
    slice_idx = 0;
    if (LSB_FIRST) slice_idx = 32'(cnt_q);
    else           slice_idx = NBEATS - 1 - 32'(cnt_q);
    slice_base = BASE_W'(slice_idx * OUT_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DS_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        DS_IDLE: begin
          if (yumi) begin
            hold_q  <= bus.data_i;
            cnt_q   <= '0;
            state_q <= DS_SEND;
          end
        end
        DS_SEND: begin
          if (beat_fire) begin
            if (!last_beat) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else if (yumi) begin
              hold_q <= bus.data_i;
              cnt_q  <= '0;
            end else begin
              state_q <= DS_IDLE;
            end
          end
        end
        default: state_q <= DS_IDLE;
      endcase
    end
  end

  assign bus.yumi_o  = yumi;
  assign bus.valid_o = send;
  assign bus.busy_o  = send;
  assign bus.last_o  = send & last_beat;
  assign bus.data_o  = send ? hold_q[slice_base +: OUT_W] : '0;

endmodule

// File: tb/tb_pipe_downsizer.sv
module tb_pipe_downsizer;
  import pipe_downsizer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst16;

  always #5 clk = ~clk;

  pipe_downsizer_if #(.OUT_W(32)) bus32 ();
  pipe_downsizer_if #(.OUT_W(16)) bus16 ();

  pipe_downsizer #(.OUT_W(32), .LSB_FIRST(1'b1)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  pipe_downsizer #(.OUT_W(16), .LSB_FIRST(1'b0)) dut16 (
    .clk (clk),
    .rst (rst16),
    .bus (bus16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Advance to just after the next active edge; inputs are driven here and
  // outputs are sampled one time unit later, well clear of the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst16 = 1'b1;
    bus32.valid_i = 1'b1; bus32.data_i = 64'hffff_ffff_ffff_ffff; bus32.ready_i = 1'b1;
    bus16.valid_i = 1'b0; bus16.data_i = '0; bus16.ready_i = 1'b1;
    cyc(); cyc();
    #1;
    n_cmp++; if (bus32.valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus32.valid_o); end
    n_cmp++; if (bus32.data_o !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%h exp=00000000", bus32.data_o); end
    n_cmp++; if (bus32.last_o !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%b exp=0", bus32.last_o); end
    n_cmp++; if (bus32.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus32.busy_o); end
    n_cmp++; if (bus32.yumi_o !== 1'b0) begin n_bad++; $display("FAIL reset_yumi got=%b exp=0", bus32.yumi_o); end
    n_cmp++; if (bus16.valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid16 got=%b exp=0", bus16.valid_o); end
    bus32.valid_i = 1'b0;
    cyc();
    rst = 1'b0; rst16 = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    bus32.valid_i = 1'b1; bus32.data_i = 64'h1234_5678_9abc_def0; bus32.ready_i = 1'b1;
    #1;
    n_cmp++; if (bus32.yumi_o !== 1'b1) begin n_bad++; $display("FAIL single_pop got=%b exp=1", bus32.yumi_o); end
    n_cmp++; if (bus32.valid_o !== 1'b0) begin n_bad++; $display("FAIL single_lat got=%b exp=0", bus32.valid_o); end
    cyc();
    bus32.valid_i = 1'b0; bus32.data_i = 64'h5a5a_5a5a_5a5a_5a5a;
    #1;
    n_cmp++; if (bus32.yumi_o !== 1'b0) begin n_bad++; $display("FAIL single_yumi_pulse got=%b exp=0", bus32.yumi_o); end
    n_cmp++; if (bus32.data_o !== 32'h9abc_def0) begin n_bad++; $display("FAIL single_b0 got=%h exp=9abcdef0", bus32.data_o); end
    n_cmp++; if (bus32.last_o !== 1'b0) begin n_bad++; $display("FAIL single_b0_last got=%b exp=0", bus32.last_o); end
    n_cmp++; if (bus32.busy_o !== 1'b1) begin n_bad++; $display("FAIL single_busy got=%b exp=1", bus32.busy_o); end
    cyc(); #1;
    n_cmp++; if (bus32.data_o !== 32'h1234_5678) begin n_bad++; $display("FAIL single_b1 got=%h exp=12345678", bus32.data_o); end
    n_cmp++; if (bus32.last_o !== 1'b1) begin n_bad++; $display("FAIL single_b1_last got=%b exp=1", bus32.last_o); end
    cyc(); #1;
    n_cmp++; if (bus32.valid_o !== 1'b0) begin n_bad++; $display("FAIL single_done got=%b exp=0", bus32.valid_o); end
    n_cmp++; if (bus32.data_o !== 32'h0) begin n_bad++; $display("FAIL single_idle_data got=%h exp=00000000", bus32.data_o); end
    cyc();
  endtask

  task automatic test_back_to_back();
    bus32.valid_i = 1'b1; bus32.data_i = 64'h0000_0000_600d_600d; bus32.ready_i = 1'b1;
    #1;
    n_cmp++; if (bus32.yumi_o !== 1'b1) begin n_bad++; $display("FAIL b2b_pop0 got=%b exp=1", bus32.yumi_o); end
    cyc();
    bus32.data_i = 64'hdead_beef_dead_beef;
    #1;
    n_cmp++; if (bus32.data_o !== 32'h600d_600d) begin n_bad++; $display("FAIL b2b_b0 got=%h exp=600d600d", bus32.data_o); end
    n_cmp++; if (bus32.yumi_o !== 1'b0) begin n_bad++; $display("FAIL b2b_nopop got=%b exp=0", bus32.yumi_o); end
    cyc(); #1;
    n_cmp++; if (bus32.data_o !== 32'h0) begin n_bad++; $display("FAIL b2b_b1 got=%h exp=00000000", bus32.data_o); end
    n_cmp++; if (bus32.last_o !== 1'b1) begin n_bad++; $display("FAIL b2b_b1_last got=%b exp=1", bus32.last_o); end
    n_cmp++; if (bus32.yumi_o !== 1'b1) begin n_bad++; $display("FAIL b2b_pop1 got=%b exp=1", bus32.yumi_o); end
    cyc();
    bus32.valid_i = 1'b0;
    #1;
    n_cmp++; if (bus32.valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_nobubble got=%b exp=1", bus32.valid_o); end
    n_cmp++; if (bus32.data_o !== 32'hdead_beef) begin n_bad++; $display("FAIL b2b_b2 got=%h exp=deadbeef", bus32.data_o); end
    n_cmp++; if (bus32.last_o !== 1'b0) begin n_bad++; $display("FAIL b2b_b2_last got=%b exp=0", bus32.last_o); end
    cyc(); #1;
    n_cmp++; if (bus32.data_o !== 32'hdead_beef) begin n_bad++; $display("FAIL b2b_b3 got=%h exp=deadbeef", bus32.data_o); end
    n_cmp++; if (bus32.last_o !== 1'b1) begin n_bad++; $display("FAIL b2b_b3_last got=%b exp=1", bus32.last_o); end
    cyc(); #1;
    n_cmp++; if (bus32.valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_done got=%b exp=0", bus32.valid_o); end
    cyc();
  endtask

  task automatic test_backpressure();
    bus32.valid_i = 1'b1; bus32.data_i = 64'habcd_abcd_1111_2222; bus32.ready_i = 1'b1;
    #1;
    n_cmp++; if (bus32.yumi_o !== 1'b1) begin n_bad++; $display("FAIL bp_pop got=%b exp=1", bus32.yumi_o); end
    cyc();
    bus32.data_i = 64'h7777_7777_8888_8888;
    for (int i = 0; i < 3; i++) begin
      bus32.ready_i = 1'b0;
      #1;
      n_cmp++; if (bus32.data_o !== 32'h1111_2222) begin n_bad++; $display("FAIL bp_hold%0d got=%h exp=11112222", i, bus32.data_o); end
      n_cmp++; if (bus32.valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_valid%0d got=%b exp=1", i, bus32.valid_o); end
      n_cmp++; if (bus32.yumi_o !== 1'b0) begin n_bad++; $display("FAIL bp_yumi%0d got=%b exp=0", i, bus32.yumi_o); end
      cyc();
    end
    bus32.ready_i = 1'b1; bus32.valid_i = 1'b0;
    #1;
    n_cmp++; if (bus32.data_o !== 32'h1111_2222) begin n_bad++; $display("FAIL bp_release got=%h exp=11112222", bus32.data_o); end
    n_cmp++; if (bus32.last_o !== 1'b0) begin n_bad++; $display("FAIL bp_release_last got=%b exp=0", bus32.last_o); end
    cyc(); #1;
    n_cmp++; if (bus32.data_o !== 32'habcd_abcd) begin n_bad++; $display("FAIL bp_b1 got=%h exp=abcdabcd", bus32.data_o); end
    n_cmp++; if (bus32.last_o !== 1'b1) begin n_bad++; $display("FAIL bp_b1_last got=%b exp=1", bus32.last_o); end
    cyc(); #1;
    n_cmp++; if (bus32.valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_done got=%b exp=0", bus32.valid_o); end
    cyc();
  endtask

  task automatic test_reset_mid();
    bus32.valid_i = 1'b1; bus32.data_i = 64'hcafe_f00d_0bad_c0de; bus32.ready_i = 1'b1;
    #1;
    n_cmp++; if (bus32.yumi_o !== 1'b1) begin n_bad++; $display("FAIL rm_pop got=%b exp=1", bus32.yumi_o); end
    cyc();
    bus32.valid_i = 1'b0;
    #1;
    n_cmp++; if (bus32.data_o !== 32'h0bad_c0de) begin n_bad++; $display("FAIL rm_b0 got=%h exp=0badc0de", bus32.data_o); end
    cyc();
    // Second beat is on the bus but not accepted; reset discards it.
    rst = 1'b1; bus32.ready_i = 1'b0;
    bus32.valid_i = 1'b1; bus32.data_i = 64'h0000_0001_0000_0002;
    #1;
    n_cmp++; if (bus32.yumi_o !== 1'b0) begin n_bad++; $display("FAIL rm_yumi_in_rst got=%b exp=0", bus32.yumi_o); end
    cyc();
    rst = 1'b0; bus32.valid_i = 1'b0; bus32.ready_i = 1'b1;
    #1;
    n_cmp++; if (bus32.valid_o !== 1'b0) begin n_bad++; $display("FAIL rm_valid got=%b exp=0", bus32.valid_o); end
    n_cmp++; if (bus32.yumi_o !== 1'b0) begin n_bad++; $display("FAIL rm_yumi got=%b exp=0", bus32.yumi_o); end
    bus32.valid_i = 1'b1;
    #1;
    n_cmp++; if (bus32.yumi_o !== 1'b1) begin n_bad++; $display("FAIL rm_repop got=%b exp=1", bus32.yumi_o); end
    cyc();
    bus32.valid_i = 1'b0;
    #1;
    n_cmp++; if (bus32.data_o !== 32'h0000_0002) begin n_bad++; $display("FAIL rm_new_b0 got=%h exp=00000002", bus32.data_o); end
    cyc(); #1;
    n_cmp++; if (bus32.data_o !== 32'h0000_0001) begin n_bad++; $display("FAIL rm_new_b1 got=%h exp=00000001", bus32.data_o); end
    n_cmp++; if (bus32.last_o !== 1'b1) begin n_bad++; $display("FAIL rm_new_last got=%b exp=1", bus32.last_o); end
    cyc(); #1;
    n_cmp++; if (bus32.valid_o !== 1'b0) begin n_bad++; $display("FAIL rm_done got=%b exp=0", bus32.valid_o); end
    cyc();
  endtask

  task automatic test_narrow_msb();
    logic [15:0] exp_beat [4];
    int          pops;
    exp_beat[0] = 16'h0123; exp_beat[1] = 16'h4567;
    exp_beat[2] = 16'h89ab; exp_beat[3] = 16'hcdef;
    pops = 0;
    bus16.valid_i = 1'b1; bus16.data_i = 64'h0123_4567_89ab_cdef; bus16.ready_i = 1'b1;
    #1;
    if (bus16.yumi_o === 1'b1) pops++;
    cyc();
    bus16.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus16.yumi_o === 1'b1) pops++;
      n_cmp++; if (bus16.data_o !== exp_beat[i]) begin n_bad++; $display("FAIL n16_beat%0d got=%h exp=%h", i, bus16.data_o, exp_beat[i]); end
      n_cmp++; if (bus16.last_o !== (i == 3)) begin n_bad++; $display("FAIL n16_last%0d got=%b exp=%b", i, bus16.last_o, (i == 3)); end
      cyc();
    end
    #1;
    n_cmp++; if (bus16.valid_o !== 1'b0) begin n_bad++; $display("FAIL n16_done got=%b exp=0", bus16.valid_o); end
    n_cmp++; if (pops !== 1) begin n_bad++; $display("FAIL n16_pops got=%0d exp=1", pops); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_narrow_msb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
